// File: rtl/ov7670_sccb_init_sequencer_if.sv
// Bus between the init sequencer, its register-table ROM and the SCCB core.
// The master side is the sequencer; the slave side is the ROM plus the core.
interface ov7670_sccb_init_sequencer_if #(
    parameter int unsigned ROM_ADDR_W = 8
);
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [15:0]           rom_data;
    logic [7:0]            main_addr;
    logic [7:0]            sub_addr;
    logic [7:0]            data;
    logic [2:0]            phase;
    logic [2:0]            phase_done;

    modport master (
        output rom_addr, main_addr, sub_addr, data, phase,
        input  rom_data, phase_done
    );

    modport slave (
        input  rom_addr, main_addr, sub_addr, data, phase,
        output rom_data, phase_done
    );
endinterface

// File: rtl/ov7670_sccb_init_sequencer.sv
// OV7670 power-up programmer: walks a {sub_addr, data} ROM table and issues one
// SCCB 3-phase write per entry; 16'hFFFF ends the table, 16'hFFF0 inserts a delay.
module ov7670_sccb_init_sequencer #(
    parameter int unsigned SYS_CLK_FREQ   = 100_000_000,
    parameter logic [7:0]  MAIN_ADDR      = 8'h42,
    parameter int unsigned ROM_ADDR_W     = 8,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned DELAY_CYCLES   = SYS_CLK_FREQ / 100,
    parameter int unsigned TIMEOUT_CYCLES = SYS_CLK_FREQ / 100,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_p,
    input  logic                          i_start,
    ov7670_sccb_init_sequencer_if.master  bus,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_error,
    output logic [ROM_ADDR_W-1:0]         o_write_count
);

    localparam logic [31:0] GAP_LD     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] DELAY_LD   = 32'(DELAY_CYCLES - 1);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_DONE,
        S_GAP, S_DELAY, S_DONE, S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [ROM_ADDR_W-1:0] addr_q, addr_d;
    logic [ROM_ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]            sub_q, sub_d;
    logic [7:0]            data_q, data_d;
    logic                  phase_q, phase_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  first_q;
    logic                  unused_phase_done;

    always_ff @(posedge i_clk or posedge i_reset_p) begin
        if (i_reset_p) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wcnt_q  <= '0;
            sub_q   <= '0;
            data_q  <= '0;
            phase_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            sub_q   <= sub_d;
            data_q  <= data_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            first_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        sub_d   = sub_q;
        data_d  = data_q;
        phase_d = phase_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start || (AUTO_START && first_q)) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (bus.rom_data == MARK_END) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (bus.rom_data == MARK_DELAY) begin
                    state_d = S_DELAY;
                    cnt_d   = DELAY_LD;
                end else begin
                    sub_d   = bus.rom_data[15:8];
                    data_d  = bus.rom_data[7:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                phase_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            // done beats a timeout landing on the same cycle
            S_WAIT_DONE: begin
                if (bus.phase_done[0]) begin
                    phase_d = 1'b0;
                    wcnt_d  = wcnt_q + 1'b1;
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    phase_d = 1'b0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP, S_DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 32'd1;
                end else if (&addr_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rom_addr  = addr_q;
    assign bus.main_addr = MAIN_ADDR;
    assign bus.sub_addr  = sub_q;
    assign bus.data      = data_q;
    assign bus.phase     = {2'b00, phase_q};
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_error       = err_q;
    assign o_write_count = wcnt_q;

    assign unused_phase_done = ^bus.phase_done[2:1];

endmodule

// File: tb/tb_ov7670_sccb_init_sequencer.sv
// Bench for the OV7670 init sequencer: registered ROM, reactive SCCB core model
// and a table-walk reference model predicting writes, status and run length.
module tb_ov7670_sccb_init_sequencer;
    localparam int AW  = 2;
    localparam int GAP = 4;
    localparam int DLY = 20;
    localparam int TMO = 100;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, error;
    logic [AW-1:0] wcnt;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;

    ov7670_sccb_init_sequencer_if #(.ROM_ADDR_W(AW)) bus ();

    ov7670_sccb_init_sequencer #(
        .ROM_ADDR_W(AW), .GAP_CYCLES(GAP), .DELAY_CYCLES(DLY),
        .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)
    ) dut (
        .i_clk(clk), .i_reset_p(rst), .i_start(start), .bus(bus),
        .o_busy(busy), .o_done(done), .o_error(error),
        .o_write_count(wcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rom [4];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // core model: done[0] lat cycles after phase[0] rises (lat 0 = never)
    int lat   = 50;
    bit noise = 1'b0;
    int hi_cnt = 0;
    always @(negedge clk) begin : core_model
        logic [2:0] pd;
        pd = 3'b000;
        if (bus.phase[0]) begin
            hi_cnt++;
            if (lat != 0 && hi_cnt == lat) pd[0] = 1'b1;
        end else begin
            hi_cnt = 0;
            if (noise) pd[0] = ($urandom_range(0, 3) == 0);
        end
        if (noise) pd[2:1] = 2'($urandom);
        bus.phase_done = pd;
    end

    logic [15:0] wr_q[$];
    int unsigned rise_q[$];
    int unsigned fall_q[$];
    bit          prev_ph = 1'b0;
    logic [15:0] cur_w;
    always @(negedge clk) begin : monitor
        if (rst) begin
            prev_ph = 1'b0;
        end else begin
            if (bus.phase[0] && !prev_ph) begin
                cur_w = {bus.sub_addr, bus.data};
                wr_q.push_back(cur_w);
                rise_q.push_back(cyc);
            end else if (bus.phase[0]) begin
                vectors++;
                if ({bus.sub_addr, bus.data} !== cur_w) begin
                    miscompares++;
                    $display("FAIL hold: got %h want %h",
                             {bus.sub_addr, bus.data}, cur_w);
                end
            end
            if (!bus.phase[0] && prev_ph) fall_q.push_back(cyc);
            prev_ph = bus.phase[0];
        end
        if (!rst && bus.phase[2:1] !== 2'b00) begin
            vectors++;
            miscompares++;
            $display("FAIL phase_hi: got %b want 00", bus.phase[2:1]);
        end
    end

    logic [15:0] exp_q[$];
    bit          e_done, e_err;
    int          e_cnt, e_addr;
    int unsigned e_time;

    // expected writes, final status and cycles from run start to done/error
    function automatic void run_model();
        int unsigned t;
        t = 1;
        exp_q.delete();
        e_done = 1'b0;
        e_err  = 1'b0;
        e_cnt  = 0;
        e_addr = 0;
        for (int a = 0; a < 4; a++) begin
            e_addr = a;
            if (rom[a] == 16'hFFFF) begin
                e_done = 1'b1;
                e_time = t + 2;
                return;
            end
            if (rom[a] == 16'hFFF0) begin
                t += 2 + DLY;
                continue;
            end
            exp_q.push_back(rom[a]);
            if (lat == 0) begin
                e_err  = 1'b1;
                e_time = t + 3 + TMO;
                return;
            end
            e_cnt++;
            t += 3 + lat + GAP;
        end
        e_done = 1'b1;
        e_time = t;
    endfunction

    task automatic clear_mon();
        wr_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic pulse_start(output int unsigned t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc, output bit ok,
                            output int unsigned t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rom[0] = 16'h1280; rom[1] = 16'hFFF0;
        rom[2] = 16'h1101; rom[3] = 16'hFFFF;
        lat = 50; noise = 1'b0; rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.phase !== 3'b000) begin miscompares++;
            $display("FAIL rst_phase: got %b want 000", bus.phase); end
        vectors++; if (bus.sub_addr !== 8'h00) begin miscompares++;
            $display("FAIL rst_sub: got %h want 00", bus.sub_addr); end
        vectors++; if (bus.data !== 8'h00) begin miscompares++;
            $display("FAIL rst_data: got %h want 00", bus.data); end
        vectors++; if (bus.rom_addr !== 2'd0) begin miscompares++;
            $display("FAIL rst_addr: got %0d want 0", bus.rom_addr); end
        vectors++; if (busy !== 1'b0) begin miscompares++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++;
            $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (error !== 1'b0) begin miscompares++;
            $display("FAIL rst_error: got %b want 0", error); end
        vectors++; if (wcnt !== 2'd0) begin miscompares++;
            $display("FAIL rst_wcnt: got %0d want 0", wcnt); end
        vectors++; if (bus.main_addr !== 8'h42) begin miscompares++;
            $display("FAIL main_addr: got %h want 42", bus.main_addr); end
    endtask

    task automatic test_table();
        int unsigned t0, td;
        bit ok;
        clear_mon();
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        run_model();
        wait_end(3000, ok, td);
        vectors++; if (!ok || done !== 1'b1 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL tbl_status: got done=%b err=%b want 1 0",
                     done, error); end
        vectors++; if (busy !== 1'b0 || wcnt !== 2'd2) begin miscompares++;
            $display("FAIL tbl_cnt: got busy=%b wcnt=%0d want 0 2",
                     busy, wcnt); end
        vectors++;
        if (wr_q.size() != 2 || fall_q.size() < 1) begin miscompares++;
            $display("FAIL tbl_nwr: got %0d want 2", wr_q.size());
        end else begin
            vectors++; if (wr_q[0] !== 16'h1280 || wr_q[1] !== 16'h1101)
            begin miscompares++;
                $display("FAIL tbl_wr: got %h %h want 1280 1101",
                         wr_q[0], wr_q[1]); end
            vectors++; if (rise_q[0] - t0 != 4) begin miscompares++;
                $display("FAIL tbl_lat: got %0d want 4", rise_q[0] - t0); end
            vectors++; if (rise_q[1] - fall_q[0] != GAP + 3 + DLY + 2)
            begin miscompares++;
                $display("FAIL tbl_pause: got %0d want %0d",
                         rise_q[1] - fall_q[0], GAP + 3 + DLY + 2); end
        end
        vectors++; if (td - t0 != e_time) begin miscompares++;
            $display("FAIL tbl_time: got %0d want %0d", td - t0, e_time); end
    endtask

    task automatic test_timeout();
        int unsigned t0, td;
        bit ok;
        rom[0] = 16'hFFF0; rom[1] = 16'h1280;
        rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        lat = 0;
        clear_mon();
        run_model();
        pulse_start(t0);
        wait_end(2000, ok, td);
        vectors++; if (!ok || error !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL to_status: got err=%b done=%b want 1 0",
                     error, done); end
        vectors++; if (bus.phase !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL to_phase: got %b busy=%b want 000 0",
                     bus.phase, busy); end
        vectors++; if (rise_q.size() != 1) begin miscompares++;
            $display("FAIL to_nrise: got %0d want 1", rise_q.size());
        end else begin
            vectors++; if (td - rise_q[0] != TMO) begin miscompares++;
                $display("FAIL to_cycles: got %0d want %0d",
                         td - rise_q[0], TMO); end
        end
        vectors++; if (td - t0 != e_time ||
                       bus.rom_addr !== 2'(e_addr)) begin miscompares++;
            $display("FAIL to_time: got %0d addr %0d want %0d addr %0d",
                     td - t0, bus.rom_addr, e_time, e_addr); end
        lat = 30;
        clear_mon();
        run_model();
        pulse_start(t0);
        vectors++; if (error !== 1'b0 || busy !== 1'b1 ||
                       bus.rom_addr !== 2'd0) begin miscompares++;
            $display("FAIL to_restart: got err=%b busy=%b addr=%0d want 0 1 0",
                     error, busy, bus.rom_addr); end
        wait_end(2000, ok, td);
        vectors++; if (!ok || done !== 1'b1 || wcnt !== 2'd1 ||
                       wr_q.size() != 1) begin miscompares++;
            $display("FAIL to_rerun: got done=%b wcnt=%0d n=%0d want 1 1 1",
                     done, wcnt, wr_q.size()); end
        vectors++; if (td - t0 != e_time) begin miscompares++;
            $display("FAIL to_rerun_time: got %0d want %0d",
                     td - t0, e_time); end
    endtask

    task automatic test_start_busy();
        int unsigned t0, td;
        bit ok;
        rom[0] = 16'h3A04; rom[1] = 16'h3A04;
        rom[2] = 16'hFFFF; rom[3] = 16'hFFFF;
        lat = 40;
        clear_mon();
        run_model();
        pulse_start(t0);
        for (int i = 0; i < 100 && rise_q.size() == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if (bus.rom_addr !== 2'd0 || wcnt !== 2'd0 ||
                           bus.phase !== 3'b001) begin miscompares++;
                $display("FAIL sb_hold: got addr=%0d wcnt=%0d ph=%b want 0 0 001",
                         bus.rom_addr, wcnt, bus.phase); end
        end
        start = 1'b0;
        wait_end(2000, ok, td);
        vectors++; if (!ok || wcnt !== 2'd2 || wr_q.size() != 2) begin
            miscompares++;
            $display("FAIL sb_end: got wcnt=%0d n=%0d want 2 2",
                     wcnt, wr_q.size()); end
        vectors++; if (td - t0 != e_time) begin miscompares++;
            $display("FAIL sb_time: got %0d want %0d", td - t0, e_time); end
    endtask

    task automatic test_full_table();
        int unsigned t0, td;
        bit ok;
        for (int a = 0; a < 4; a++) rom[a] = 16'h3A04;
        lat = $urandom_range(10, 30);
        clear_mon();
        run_model();
        pulse_start(t0);
        wait_end(2000, ok, td);
        repeat (4) @(negedge clk);
        vectors++; if (!ok || done !== 1'b1 || bus.rom_addr !== 2'd3) begin
            miscompares++;
            $display("FAIL full_end: got done=%b addr=%0d want 1 3",
                     done, bus.rom_addr); end
        vectors++; if (wr_q.size() != 4 || wcnt !== 2'(4)) begin
            miscompares++;
            $display("FAIL full_nwr: got n=%0d wcnt=%0d want 4 0",
                     wr_q.size(), wcnt); end
        vectors++; if (td - t0 != e_time) begin miscompares++;
            $display("FAIL full_time: got %0d want %0d", td - t0, e_time); end
    endtask

    task automatic test_ff01_and_tie();
        int unsigned t0, td;
        bit ok;
        rom[0] = 16'hFF01; rom[1] = 16'hFFFF;
        rom[2] = 16'h1111; rom[3] = 16'hFFFF;
        lat = 25;
        clear_mon();
        pulse_start(t0);
        wait_end(2000, ok, td);
        vectors++; if (!ok || wr_q.size() != 1 || wcnt !== 2'd1) begin
            miscompares++;
            $display("FAIL ff01_n: got n=%0d wcnt=%0d want 1 1",
                     wr_q.size(), wcnt);
        end else begin
            vectors++; if (wr_q[0] !== 16'hFF01) begin miscompares++;
                $display("FAIL ff01_wr: got %h want ff01", wr_q[0]); end
        end
        rom[0] = 16'h1234;
        lat = TMO;
        clear_mon();
        pulse_start(t0);
        wait_end(2000, ok, td);
        vectors++; if (!ok || done !== 1'b1 || error !== 1'b0 ||
                       wcnt !== 2'd1) begin miscompares++;
            $display("FAIL tie: got done=%b err=%b wcnt=%0d want 1 0 1",
                     done, error, wcnt); end
    endtask

    task automatic test_reset_mid();
        int unsigned r0, td;
        bit ok;
        rom[0] = 16'h1111; rom[1] = 16'h2222;
        rom[2] = 16'h3333; rom[3] = 16'hFFFF;
        lat = 30;
        clear_mon();
        pulse_start(r0);
        for (int i = 0; i < 300 && rise_q.size() < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.phase !== 3'b000 || bus.sub_addr !== 8'h00 ||
                       bus.data !== 8'h00 || bus.rom_addr !== 2'd0) begin
            miscompares++;
            $display("FAIL rm_bus: got ph=%b sub=%h dat=%h addr=%0d want 0",
                     bus.phase, bus.sub_addr, bus.data, bus.rom_addr); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 ||
                       wcnt !== 2'd0) begin miscompares++;
            $display("FAIL rm_status: got b=%b d=%b e=%b w=%0d want 0",
                     busy, done, error, wcnt); end
        @(negedge clk);
        clear_mon();
        run_model();
        rst = 1'b0;
        r0 = cyc;
        wait_end(2000, ok, td);
        vectors++; if (!ok || wr_q.size() != 3 || wcnt !== 2'd3) begin
            miscompares++;
            $display("FAIL rm_rerun: got n=%0d wcnt=%0d want 3 3",
                     wr_q.size(), wcnt);
        end else begin
            vectors++; if (wr_q[0] !== 16'h1111 || rise_q[0] - r0 != 4) begin
                miscompares++;
                $display("FAIL rm_first: got %h lat %0d want 1111 lat 4",
                         wr_q[0], rise_q[0] - r0); end
        end
        vectors++; if (td - r0 != e_time) begin miscompares++;
            $display("FAIL rm_time: got %0d want %0d", td - r0, e_time); end
    endtask

    task automatic test_random();
        int unsigned t0, td;
        bit ok;
        noise = 1'b1;
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < 4; a++) begin
                case ($urandom_range(0, 6))
                    0: rom[a] = 16'hFFF0;
                    1: rom[a] = 16'hFFFF;
                    2: rom[a] = 16'hFF01;
                    3: rom[a] = 16'hFFF1;
                    default: rom[a] = 16'($urandom_range(0, 'hFEFF));
                endcase
            end
            lat = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
            clear_mon();
            run_model();
            pulse_start(t0);
            wait_end(2000, ok, td);
            vectors++; if (!ok || done !== e_done || error !== e_err) begin
                miscompares++;
                $display("FAIL rnd%0d_status: got d=%b e=%b want %b %b",
                         it, done, error, e_done, e_err); end
            vectors++; if (wcnt !== 2'(e_cnt) || busy !== 1'b0 ||
                           bus.rom_addr !== 2'(e_addr)) begin miscompares++;
                $display("FAIL rnd%0d_cnt: got w=%0d a=%0d want %0d %0d",
                         it, wcnt, bus.rom_addr, e_cnt % 4, e_addr); end
            vectors++; if (td - t0 != e_time) begin miscompares++;
                $display("FAIL rnd%0d_time: got %0d want %0d",
                         it, td - t0, e_time); end
            vectors++; if (wr_q.size() != exp_q.size()) begin miscompares++;
                $display("FAIL rnd%0d_nwr: got %0d want %0d",
                         it, wr_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++;
                        $display("FAIL rnd%0d_wr%0d: got %h want %h",
                                 it, i, wr_q[i], exp_q[i]); end
                end
            end
        end
        noise = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_table();
        test_timeout();
        test_start_busy();
        test_full_table();
        test_ff01_and_tie();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
